pattern_framer0110: RTL and testbench

- Serial frame transmitter that pairs with the team's 0110 pattern detector.
- Accepts a parallel payload word and emits one frame on a single serial line: the fixed 4-bit sync pattern 0110, then the payload MSB-first.
- Inserts stuff bits into the payload so that 0110 never appears anywhere except the preamble. The receiver's 0110 detector therefore only ever fires on a frame start.
- Bit rate is set by an external bit-enable strobe.

---
 rtl/pattern_framer0110.sv | 170 +++++++++++++++++
 tb/tb_pattern_framer0110.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_framer0110.sv
// Serial frame transmitter: sync pattern 0110 followed by the payload MSB-first,
// with a 1 stuffed after every 011 so the pattern never recurs inside a frame.
module pattern_framer0110 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [3:0] PREAMBLE = 4'b0110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        DATA  = 2'd2,
        STUFF = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [DATA_W-1:0]  shift_r, shift_s;
    logic [2:0]         hist_r, hist_s;
    logic [1:0]         pre_cnt_r, pre_cnt_s;
    logic [CNT_W-1:0]   pay_cnt_r, pay_cnt_s;
    logic               ready_r, ready_s;
    logic               ser_out_r, ser_out_s;
    logic               ser_valid_r, ser_valid_s;
    logic               done_r, done_s;

    logic               emit_s;
    logic               emit_bit_s;
    logic [2:0]         hist_upd_s;

    // A stuff bit is due whenever the last three line bits read 011.
    function automatic logic needs_stuff(input logic [2:0] hist);
        return (hist == 3'b011);
    endfunction

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            shift_r     <= {DATA_W{1'b0}};
            hist_r      <= 3'b111;
            pre_cnt_r   <= 2'd0;
            pay_cnt_r   <= {CNT_W{1'b0}};
            ready_r     <= 1'b1;
            ser_out_r   <= 1'b1;
            ser_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            hist_r      <= hist_s;
            pre_cnt_r   <= pre_cnt_s;
            pay_cnt_r   <= pay_cnt_s;
            ready_r     <= ready_s;
            ser_out_r   <= ser_out_s;
            ser_valid_r <= ser_valid_s;
            done_r      <= done_s;
        end
    end

    // Bit selection for the current state and the resulting history.
    always_comb begin
        emit_s = bit_en && (state_r != IDLE);
        case (state_r)
            PRE:     emit_bit_s = PREAMBLE[2'd3 - pre_cnt_r];
            DATA:    emit_bit_s = shift_r[DATA_W-1];
            STUFF:   emit_bit_s = 1'b1;
            default: emit_bit_s = 1'b1;
        endcase
        hist_upd_s = {hist_r[1:0], emit_bit_s};
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = PRE;
                end else begin
                    state_s = IDLE;
                end
            end
            PRE: begin
                if (bit_en && (pre_cnt_r == 2'd3)) begin
                    state_s = DATA;
                end else begin
                    state_s = PRE;
                end
            end
            DATA: begin
                // The stuff check also covers the final payload bit.
                if (!bit_en) begin
                    state_s = DATA;
                end else if (needs_stuff(hist_upd_s)) begin
                    state_s = STUFF;
                end else if (pay_cnt_r == CNT_W'(DATA_W - 1)) begin
                    state_s = IDLE;
                end else begin
                    state_s = DATA;
                end
            end
            STUFF: begin
                if (!bit_en) begin
                    state_s = STUFF;
                end else if (pay_cnt_r == CNT_W'(DATA_W)) begin
                    state_s = IDLE;
                end else begin
                    state_s = DATA;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        shift_s     = shift_r;
        hist_s      = hist_r;
        pre_cnt_s   = pre_cnt_r;
        pay_cnt_s   = pay_cnt_r;
        ready_s     = ready_r;
        ser_out_s   = ser_out_r;
        ser_valid_s = 1'b0;
        done_s      = 1'b0;
        if (state_r == IDLE) begin
            ser_out_s = 1'b1;
            if (start) begin
                shift_s   = data_in;
                pre_cnt_s = 2'd0;
                pay_cnt_s = {CNT_W{1'b0}};
                ready_s   = 1'b0;
            end else begin
                ready_s   = 1'b1;
            end
        end else if (emit_s) begin
            ser_out_s   = emit_bit_s;
            ser_valid_s = 1'b1;
            hist_s      = hist_upd_s;
            done_s      = (state_s == IDLE);
            ready_s     = (state_s == IDLE);
            case (state_r)
                PRE:     pre_cnt_s = pre_cnt_r + 2'd1;
                DATA: begin
                    shift_s   = {shift_r[DATA_W-2:0], 1'b0};
                    pay_cnt_s = pay_cnt_r + CNT_W'(1);
                end
                default: pre_cnt_s = pre_cnt_r;
            endcase
        end else begin
            ser_out_s = ser_out_r;
        end
    end

    assign ready     = ready_r;
    assign ser_out   = ser_out_r;
    assign ser_valid = ser_valid_r;
    assign done      = done_r;

endmodule

// File: tb/tb_pattern_framer0110.sv
// Self-checking bench for pattern_framer0110: directed and randomised frames
// compared bit by bit against a list-based frame model.
module tb_pattern_framer0110;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          bit_en;
    logic          start;
    logic [DW-1:0] data_in;
    logic          ready;
    logic          ser_out;
    logic          ser_valid;
    logic          done;

    int   checks;
    int   errors;
    logic exp_q[$];

    pattern_framer0110 #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .start     (start),
        .data_in   (data_in),
        .ready     (ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame model: preamble, payload MSB-first, a 1 appended whenever the list ends in 0,1,1.
    task automatic build_frame(input logic [DW-1:0] d);
        int n;
        exp_q.delete();
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        for (int i = DW - 1; i >= 0; i--) begin
            exp_q.push_back(d[i]);
            n = exp_q.size();
            if (exp_q[n-3] == 1'b0 && exp_q[n-2] == 1'b1 && exp_q[n-1] == 1'b1)
                exp_q.push_back(1'b1);
        end
    endtask

    task automatic check_idle(input string tag);
        chk1({tag, "_ser_out"}, ser_out, 1'b1);
        chk1({tag, "_valid"}, ser_valid, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_ready"}, ready, 1'b1);
    endtask

    // mode 0: bit_en always 1; mode 1: every 3rd cycle; mode 2: random. abort_at>=0 resets after that many bits.
    task automatic run_frame(input logic [DW-1:0] d, input int mode, input int exp_len, input int abort_at);
        int   idx;
        int   cyc;
        int   last;
        int   hits;
        int   hit_pos;
        logic be;
        logic last_bit;
        logic got[$];
        build_frame(d);
        if (exp_len > 0) chkn("frame_len_model", exp_q.size(), exp_len);
        last = exp_q.size() - 1;
        chk1("ready_before_start", ready, 1'b1);
        start   = 1'b1;
        data_in = d;
        bit_en  = 1'b1;
        step();
        start = 1'b0;
        chk1("accept_no_valid", ser_valid, 1'b0);
        chk1("accept_ready_low", ready, 1'b0);
        chk1("accept_ser_idle", ser_out, 1'b1);
        idx = 0;
        cyc = 0;
        last_bit = 1'b1;
        while (idx <= last && cyc < 2000) begin
            case (mode)
                0:       be = 1'b1;
                1:       be = ((cyc % 3) == 2);
                default: be = ($urandom_range(0, 2) != 0);
            endcase
            bit_en  = be;
            data_in = DW'($urandom);
            start   = ((cyc % 5) == 1);
            if (abort_at >= 0 && idx == abort_at) begin
                rst_n = 1'b0;
                step();
                check_idle("abort");
                rst_n  = 1'b1;
                start  = 1'b0;
                bit_en = 1'b0;
                step();
                check_idle("after_abort");
                return;
            end
            step();
            cyc++;
            if (be) begin
                got.push_back(ser_out);
                chk1("bit_valid", ser_valid, 1'b1);
                chk1("bit_value", ser_out, exp_q[idx]);
                chk1("bit_done", done, (idx == last));
                chk1("bit_ready", ready, (idx == last));
                last_bit = exp_q[idx];
                idx++;
            end else begin
                chk1("stall_valid", ser_valid, 1'b0);
                chk1("stall_done", done, 1'b0);
                chk1("stall_hold", ser_out, last_bit);
                chk1("stall_ready", ready, 1'b0);
            end
        end
        if (cyc >= 2000) chkn("frame_timeout", cyc, -1);
        start  = 1'b0;
        bit_en = 1'b0;
        step();
        check_idle("post_frame");
        hits = 0;
        hit_pos = -1;
        for (int i = 3; i < got.size(); i++) begin
            if (got[i-3] == 1'b0 && got[i-2] == 1'b1 && got[i-1] == 1'b1 && got[i] == 1'b0) begin
                hits++;
                hit_pos = i;
            end
        end
        chkn("detect_count", hits, 1);
        chkn("detect_pos", hit_pos, 3);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        bit_en  = 1'b0;
        start   = 1'b0;
        data_in = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("reset");
        step();
        step();
        check_idle("reset_hold");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            bit_en = i[0];
            step();
            check_idle("idle");
        end

        run_frame(8'h00, 0, 12, -1);
        run_frame(8'hFF, 0, 13, -1);
        run_frame(8'h6C, 0, 14, -1);
        run_frame(8'h6C, 1, 14, -1);
        run_frame(8'hFF, 0, 13, 6);
        run_frame(8'h00, 0, 12, -1);

        for (int k = 0; k < 20; k++) begin
            run_frame(DW'($urandom), 2, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
